// File: rtl/block_serializer_64.sv
// -----------------------------------------------------------------------------
// block_serializer_64
//
// Purpose:
//   Takes one BLOCK_W-bit block (a DES result) over a valid/ready input port
//   and streams it out as BLOCK_W/8 bytes over a valid/ready byte port that
//   feeds the I2C slave TX byte buffer.
//
// Handshake semantics (both ports):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   valid never depends on ready.
//   While valid is high and ready is low, the payload is held unchanged.
//   On the block port, a transfer seen together with abort=1 is dropped.
//
// Parameters:
//   BLOCK_W    block width in bits (multiple of 8, >= 16)
//   MSB_FIRST  1: byte [BLOCK_W-1 -: 8] goes out first, 0: byte [7:0] first
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset (priority over abort)
//   blk_data   block to serialize, sampled on accept
//   blk_valid  producer has a block
//   blk_ready  block port can accept (high in IDLE only)
//   abort      synchronous flush of the in-flight block
//   tx_byte    current output byte (8'h00 while idle)
//   tx_valid   tx_byte is valid
//   tx_ready   sink consumes tx_byte this cycle
//   tx_last    tx_byte is the final byte of the block
//   busy       a block is held (state SEND)
//   tx_parity  even parity of tx_byte, only when SER_PARITY_EN is defined
//   dbg_state  FSM state (0 = IDLE, 1 = SEND)
//
// Optional feature macro: SER_PARITY_EN
// -----------------------------------------------------------------------------
module block_serializer_64 #(
  parameter int BLOCK_W   = 64,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] blk_data,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic               abort,
  output logic [7:0]         tx_byte,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last,
  output logic               busy,
`ifdef SER_PARITY_EN
  output logic               tx_parity,
`endif
  output logic               dbg_state
);

  localparam int NB = BLOCK_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CW-1:0]      r_cnt;
  logic [BLOCK_W-1:0] r_shift;
  logic [BLOCK_W-1:0] w_shift_next;
  logic               w_accept;
  logic               w_take;
  logic               w_last;

  // Byte sitting at the output end of a shift-register image.
  function automatic logic [7:0] out_byte(input logic [BLOCK_W-1:0] v);
    if (MSB_FIRST) return v[BLOCK_W-1 -: 8];
    else           return v[7:0];
  endfunction

  assign w_accept = (r_state == IDLE) && blk_valid;
  assign w_take   = (r_state == SEND) && tx_ready;
  assign w_last   = (r_cnt == LAST_CNT);

  // Move the next byte toward the output end.
  assign w_shift_next = MSB_FIRST ? {r_shift[BLOCK_W-9:0], 8'h00}
                                  : {8'h00, r_shift[BLOCK_W-1:8]};

  // Next-state logic; abort overrides any handshake seen in the same cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (blk_valid)         w_state_next = SEND;
      SEND:    if (tx_ready && w_last) w_state_next = IDLE;
      default:                        w_state_next = IDLE;
    endcase
    if (abort) w_state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Datapath. On the final byte the shift register is not advanced; the
  // output is gated off in IDLE so the stale contents are never visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (abort) begin
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shift <= blk_data;
      r_cnt   <= '0;
    end else if (w_take && !w_last) begin
      r_shift <= w_shift_next;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

`ifdef SER_PARITY_EN
  // Parity is registered with the byte it describes, so it is computed from
  // the value the shift register is about to take.
  logic r_parity;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (abort) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^out_byte(blk_data);
    end else if (w_take && !w_last) begin
      r_parity <= ^out_byte(w_shift_next);
    end
  end

  assign tx_parity = (r_state == SEND) ? r_parity : 1'b0;
`endif

  assign blk_ready = (r_state == IDLE);
  assign tx_valid  = (r_state == SEND);
  assign busy      = (r_state == SEND);
  assign tx_byte   = (r_state == SEND) ? out_byte(r_shift) : 8'h00;
  assign tx_last   = (r_state == SEND) && w_last;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_block_serializer_64.sv
module tb_block_serializer_64;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] blk_data;
  logic        blk_valid;
  logic        abort;
  logic        tx_ready;

  logic        m_blk_ready, m_tx_valid, m_tx_last, m_busy, m_dbg;
  logic [7:0]  m_tx_byte;
  logic        l_blk_ready, l_tx_valid, l_tx_last, l_busy, l_dbg;
  logic [7:0]  l_tx_byte;
`ifdef SER_PARITY_EN
  logic        m_tx_parity, l_tx_parity;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  block_serializer_64 #(.BLOCK_W(64), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_ready(m_blk_ready), .abort(abort), .tx_byte(m_tx_byte),
    .tx_valid(m_tx_valid), .tx_ready(tx_ready), .tx_last(m_tx_last),
    .busy(m_busy),
`ifdef SER_PARITY_EN
    .tx_parity(m_tx_parity),
`endif
    .dbg_state(m_dbg)
  );

  block_serializer_64 #(.BLOCK_W(64), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_ready(l_blk_ready), .abort(abort), .tx_byte(l_tx_byte),
    .tx_valid(l_tx_valid), .tx_ready(tx_ready), .tx_last(l_tx_last),
    .busy(l_busy),
`ifdef SER_PARITY_EN
    .tx_parity(l_tx_parity),
`endif
    .dbg_state(l_dbg)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Both instances idle: ready for a block, nothing on the byte port.
  task automatic check_idle(input string tag);
    check({tag, " m_blk_ready"}, {7'd0, m_blk_ready}, 8'd1);
    check({tag, " m_tx_valid"},  {7'd0, m_tx_valid},  8'd0);
    check({tag, " m_busy"},      {7'd0, m_busy},      8'd0);
    check({tag, " m_tx_last"},   {7'd0, m_tx_last},   8'd0);
    check({tag, " m_tx_byte"},   m_tx_byte,           8'h00);
    check({tag, " m_dbg"},       {7'd0, m_dbg},       8'd0);
    check({tag, " l_blk_ready"}, {7'd0, l_blk_ready}, 8'd1);
    check({tag, " l_tx_valid"},  {7'd0, l_tx_valid},  8'd0);
    check({tag, " l_tx_byte"},   l_tx_byte,           8'h00);
`ifdef SER_PARITY_EN
    check({tag, " m_parity"},    {7'd0, m_tx_parity}, 8'd0);
    check({tag, " l_parity"},    {7'd0, l_tx_parity}, 8'd0);
`endif
  endtask

  task automatic check_byte(input string tag, input int i, input logic [7:0] em,
                            input logic [7:0] el);
    logic [7:0] elast;
    elast = (i == 7) ? 8'd1 : 8'd0;
    check($sformatf("%s b%0d m_tx_byte", tag, i), m_tx_byte, em);
    check($sformatf("%s b%0d l_tx_byte", tag, i), l_tx_byte, el);
    check($sformatf("%s b%0d m_tx_valid", tag, i), {7'd0, m_tx_valid}, 8'd1);
    check($sformatf("%s b%0d l_tx_valid", tag, i), {7'd0, l_tx_valid}, 8'd1);
    check($sformatf("%s b%0d m_tx_last", tag, i), {7'd0, m_tx_last}, elast);
    check($sformatf("%s b%0d l_tx_last", tag, i), {7'd0, l_tx_last}, elast);
    check($sformatf("%s b%0d m_blk_ready", tag, i), {7'd0, m_blk_ready}, 8'd0);
    check($sformatf("%s b%0d m_busy", tag, i), {7'd0, m_busy}, 8'd1);
    check($sformatf("%s b%0d m_dbg", tag, i), {7'd0, m_dbg}, 8'd1);
`ifdef SER_PARITY_EN
    check($sformatf("%s b%0d m_parity", tag, i), {7'd0, m_tx_parity}, {7'd0, ^em});
    check($sformatf("%s b%0d l_parity", tag, i), {7'd0, l_tx_parity}, {7'd0, ^el});
`endif
  endtask

  // Offer one block, then walk its bytes. stall_at: byte index held with
  // tx_ready low for 5 edges. abort_at: byte index at which abort is raised.
  task automatic send_block(input string tag, input logic [63:0] blk,
                            input int stall_at, input int abort_at);
    logic [7:0] em, el;
    @(negedge clk);
    blk_data  = blk;
    blk_valid = 1'b1;
    tx_ready  = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      em = blk[(63 - 8*i) -: 8];
      el = blk[(8*i) +: 8];
      check_byte(tag, i, em, el);
      if (i == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle({tag, " after abort"});
        return;
      end
      if (i == stall_at) begin
        tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check_byte($sformatf("%s stall%0d", tag, k), i, em, el);
        end
        tx_ready = 1'b1;
      end
      @(negedge clk);
    end
    check_idle({tag, " end"});
  endtask

  initial begin
    rst       = 1'b1;
    blk_data  = '0;
    blk_valid = 1'b0;
    abort     = 1'b0;
    tx_ready  = 1'b0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("post reset");

    // Plain stream, both byte orders (tx_ready tied high).
    send_block("stream", 64'h0123456789ABCDEF, -1, -1);

    // Backpressure on byte 3 for 5 edges.
    send_block("stall", 64'h0123456789ABCDEF, 3, -1);

    // Abort during byte 4 while tx_ready is high, then a fresh block.
    send_block("abort", 64'h0123456789ABCDEF, -1, 4);
    send_block("after_abort", 64'hFFFF0000FFFF0000, -1, -1);

    // Abort together with an accept: block is dropped.
    @(negedge clk);
    blk_data  = 64'hA5A5A5A5A5A5A5A5;
    blk_valid = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    abort     = 1'b0;
    check_idle("abort_accept");
    @(negedge clk);
    check_idle("abort_accept hold");

    // Reset in the middle of a block.
    @(negedge clk);
    blk_data  = 64'h1122334455667788;
    blk_valid = 1'b1;
    tx_ready  = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    check_byte("mid_rst", 0, 8'h11, 8'h88);
    @(negedge clk);
    check_byte("mid_rst", 1, 8'h22, 8'h77);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("mid_rst after");

    // Parity pattern block (parity checks active when the macro is defined).
    send_block("parity", 64'h0100000000000003, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
